// File: rtl/decode32_regfile.sv
// Decode-stage register file with writeback mux and immediate extender.
// Reads are combinational; one write per cycle on the rising clock edge.
module decode32_regfile #(
  parameter logic [31:0] SP_INIT = 32'h0000_7FFC
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] Instruction,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] mem_data,
  input  logic [31:0] PC_plus_4,
  input  logic        RegWrite,
  input  logic        RegDst,
  input  logic        MemtoReg,
  input  logic        Jal,
  output logic [31:0] Read_data_1,
  output logic [31:0] Read_data_2,
  output logic [31:0] Sign_extend
);

  logic [31:0] r_regs [32];

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata;
  logic        w_we;
  logic        w_zext;

  assign w_op  = Instruction[31:26];
  assign w_rs  = Instruction[25:21];
  assign w_rt  = Instruction[20:16];
  assign w_rd  = Instruction[15:11];
  assign w_imm = Instruction[15:0];

  always_comb begin
    w_zext = 1'b0;
    case (w_op)
      6'h0B, 6'h0C, 6'h0D, 6'h0E: w_zext = 1'b1;
      default:                    w_zext = 1'b0;
    endcase
  end

  assign Sign_extend = w_zext ? {16'h0000, w_imm}
                              : {{16{w_imm[15]}}, w_imm};

  always_comb begin
    w_waddr = w_rt;
    w_wdata = ALU_Result;
    if (Jal) begin
      w_waddr = 5'd31;
      w_wdata = PC_plus_4;
    end else begin
      if (RegDst)   w_waddr = w_rd;
      if (MemtoReg) w_wdata = mem_data;
    end
  end

  // $0 is never written, so it stays at its reset value of zero.
  assign w_we = (RegWrite || Jal) && (w_waddr != 5'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++)
        r_regs[i] <= (i == 29) ? SP_INIT : 32'd0;
    end else if (w_we) begin
      r_regs[w_waddr] <= w_wdata;
    end
  end

  assign Read_data_1 = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
  assign Read_data_2 = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];

endmodule

// File: doc/decode32_regfile.md
DECODE32_REGFILE -- requirements
Module: decode32_regfile

Interface
REQ-001 SHALL have parameter SP_INIT, default 32'h0000_7FFC: reset value of register $29 ($sp).
REQ-002 SHALL have clock  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have reset_n  input  1: asynchronous, active-low reset.
REQ-004 SHALL have Instruction  input  32: current instruction.
REQ-005 SHALL have ALU_Result  input  32: execute-unit result, written back for arithmetic/logic/shift/slt/lui.
REQ-006 SHALL have mem_data  input  32: load data from data memory.
REQ-007 SHALL have PC_plus_4  input  32: address of next sequential instruction, written to $31 on jal.
REQ-008 SHALL have RegWrite  input  1: writeback enable for the current instruction.
REQ-009 SHALL have RegDst  input  1: 1 = destination rd (Instruction[15:11]), 0 = destination rt (Instruction[20:16]).
REQ-010 SHALL have MemtoReg  input  1: 1 = write mem_data, 0 = write ALU_Result.
REQ-011 SHALL have Jal  input  1: jal instruction; overrides destination and data.
REQ-012 SHALL have Read_data_1  output  32: value of register rs (Instruction[25:21]).
REQ-013 SHALL have Read_data_2  output  32: value of register rt (Instruction[20:16]).
REQ-014 SHALL have Sign_extend  output  32: extended immediate Instruction[15:0].

Function
REQ-015 SHALL hold 32 registers of 32 bits; $0 reads 0 always.
REQ-016 SHALL drive Read_data_1/Read_data_2 combinationally from the register array; zero latency.
REQ-017 SHALL return the pre-write value on a same-cycle read of the register being written; new value visible after the rising edge (no bypass).
REQ-018 SHALL zero-extend the immediate for opcode Instruction[31:26] = 6'h0C (andi), 6'h0D (ori), 6'h0E (xori), 6'h0B (sltiu); sign-extend for all other opcodes.
REQ-019 SHALL select write address: Jal=1 -> 31; else RegDst=1 -> rd; else rt.
REQ-020 SHALL select write data: Jal=1 -> PC_plus_4; else MemtoReg=1 -> mem_data; else ALU_Result.
REQ-021 SHALL write the selected data to the selected register on the rising clock edge when RegWrite=1 or Jal=1, and reset_n=1.
REQ-022 SHALL discard any write whose address is 0; $0 stays 0.
REQ-023 SHALL leave all registers unchanged when RegWrite=0 and Jal=0.
REQ-024 SHALL give Jal priority over RegDst and MemtoReg when several are asserted together.
REQ-025 SHALL perform at most one register write per cycle.

Reset
REQ-026 SHALL, while reset_n=0, immediately (without waiting for a clock edge) set every register to 0, except $29, which is set to SP_INIT.
REQ-027 SHALL block writes while reset_n=0; a write pending at a clock edge coinciding with reset assertion is lost.
REQ-028 SHALL resume normal writes at the first rising edge after reset_n returns to 1; Sign_extend is unaffected by reset.

Verification
REQ-029 Reset: assert reset_n=0 mid-cycle with no clock edge, read rs=29, rt=5 -> Read_data_1=32'h0000_7FFC and Read_data_2=0 immediately.
REQ-030 R-type writeback: RegWrite=1, RegDst=1, rd=8, ALU_Result=32'h1234_5678, one edge -> rs=8 reads 32'h1234_5678; before that edge it reads 0.
REQ-031 Load plus $0: MemtoReg=1, RegDst=0, rt=9, mem_data=32'hDEAD_BEEF -> $9=32'hDEAD_BEEF. Then rt=0, RegWrite=1 -> $0 reads 0.
REQ-032 Jal priority: Jal=1, RegDst=1, MemtoReg=1, PC_plus_4=32'h0000_0404, rd=8 -> $31=32'h0000_0404 and $8 unchanged.
REQ-033 Immediates: Instruction=32'h3508_8000 (ori) -> Sign_extend=32'h0000_8000. Instruction=32'h2108_8000 (addi) -> Sign_extend=32'hFFFF_8000.
REQ-034 Read-during-write: $8=5, write 7 to $8 with rs=8 -> Read_data_1=5 before the edge, 7 after; RegWrite=0 for 3 edges -> $8 holds 7.
